// File: rtl/cam_fb_pkg.sv
// Shared types and pixel helpers for the camera frame-buffer writer.
// Reused by display-side conversion paths.
package cam_fb_pkg;

  typedef enum logic [1:0] {
    PIX_GRAY,
    PIX_RGB332,
    PIX_RGB565
  } pix_mode_t;

  typedef enum logic {
    S_WRITE,
    S_WAIT_SWAP
  } wr_state_t;

  function automatic logic [7:0] rgb565_to_gray(
    input logic [15:0] p
  );
    logic [9:0] s;
    s = {2'b0, p[15:11], 3'b0}
      + {2'b0, p[10:5], 2'b0}
      + {2'b0, p[4:0], 3'b0};
    return 8'(s >> 2) + 8'(s >> 4)
         + 8'(s >> 6);
  endfunction

  function automatic logic [7:0] rgb565_to_332(
    input logic [15:0] p
  );
    return {p[15:13], p[10:8], p[4:3]};
  endfunction

  function automatic int addr_w(
    input int h,
    input int v,
    input int k
  );
    return $clog2((h >> k) * (v >> k)) + 1;
  endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// Frame-buffer BRAM write port (port A).
// Master drives, BRAM side receives.
interface cam_frame_writer_if #(
  parameter int ADDR_W = 18,
  parameter int OUT_W  = 8
);

  logic [ADDR_W-1:0] wr_addr_out;
  logic [OUT_W-1:0]  wr_data_out;
  logic              wr_en_out;

  modport master (
    output wr_addr_out,
    output wr_data_out,
    output wr_en_out
  );

  modport slave (
    input wr_addr_out,
    input wr_data_out,
    input wr_en_out
  );

endinterface

// File: rtl/pixel_convert.sv
// One registered stage: 5-6-5 pixel to gray / rgb332 / rgb565.
// Reserved or unsupported modes fall back to gray.
module pixel_convert
  import cam_fb_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  pix_mode_t        mode_i,
  input  logic [15:0]      pixel_i,
  output logic [OUT_W-1:0] data_o
);

  logic [OUT_W-1:0] data_d;
  logic [OUT_W-1:0] data_q;

  always_comb begin
    data_d = OUT_W'(rgb565_to_gray(pixel_i));
    unique case (1'b1)
      (mode_i == PIX_RGB332):
        data_d = OUT_W'(rgb565_to_332(pixel_i));
      (mode_i == PIX_RGB565 && OUT_W == 16):
        data_d = OUT_W'(pixel_i);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Camera-to-ping-pong frame-buffer writer with decimation,
// format conversion and tear-free bank swapping.
module cam_frame_writer
  import cam_fb_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int OUT_W      = 8,
  parameter int DECIM_LOG2 = 0,
  parameter int ADDR_W     =
    addr_w(H_RES, V_RES, DECIM_LOG2)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  mode_in,
  input  logic [15:0] pixel_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  input  logic        frame_done_in,
  input  logic        nf_in,
  cam_frame_writer_if.master wr,
  output logic        rd_bank_out,
  output logic        swap_out,
  output logic [15:0] drop_count_out
);

  localparam int OFF_W = ADDR_W - 1;
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);
  localparam logic [10:0] H_MSK =
    11'((1 << DECIM_LOG2) - 1);
  localparam logic [9:0]  V_MSK =
    10'((1 << DECIM_LOG2) - 1);
  localparam logic [OFF_W-1:0] ROW_W =
    OFF_W'(H_RES >> DECIM_LOG2);

  wr_state_t         state_q;
  logic              bank_q;
  logic              swap_q;
  logic [15:0]       drop_q;
  logic [1:0]        mode_q;
  logic              mode_ld_q;
  logic [1:0]        mode_eff;

  logic              v1_q;
  logic              bank1_q;
  logic [OFF_W-1:0]  off1_q;
  logic [OUT_W-1:0]  data1;
  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [OUT_W-1:0]  data_q;

  logic              accept;
  logic              pipe_busy;
  logic              do_swap;
  logic [OFF_W-1:0]  off_d;

  // First cycle out of reset samples mode_in live.
  assign mode_eff = mode_ld_q ? mode_in : mode_q;

  assign accept = valid_in
    && (state_q == S_WRITE)
    && (hcount_in < H_LIM)
    && (vcount_in < V_LIM)
    && ((hcount_in & H_MSK) == '0)
    && ((vcount_in & V_MSK) == '0);

  assign off_d =
    OFF_W'(hcount_in >> DECIM_LOG2)
    + ROW_W * OFF_W'(vcount_in >> DECIM_LOG2);

  assign pipe_busy = v1_q | en_q;
  assign do_swap = (state_q == S_WAIT_SWAP)
    && nf_in && !pipe_busy;

  pixel_convert #(
    .OUT_W (OUT_W)
  ) u_conv (
    .clk_i   (clk_in),
    .rst_n_i (rst_in),
    .mode_i  (pix_mode_t'(mode_eff)),
    .pixel_i (pixel_in),
    .data_o  (data1)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      v1_q    <= 1'b0;
      bank1_q <= 1'b0;
      off1_q  <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        bank1_q <= bank_q;
        off1_q  <= off_d;
      end
      en_q <= v1_q;
      if (v1_q) begin
        addr_q <= {bank1_q, off1_q};
        data_q <= data1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_WRITE;
      bank_q    <= 1'b0;
      swap_q    <= 1'b0;
      drop_q    <= '0;
      mode_q    <= 2'(PIX_GRAY);
      mode_ld_q <= 1'b1;
    end else begin
      swap_q    <= do_swap;
      mode_ld_q <= 1'b0;
      if (mode_ld_q) begin
        mode_q <= mode_in;
      end
      unique case (state_q)
        S_WRITE: begin
          if (frame_done_in) begin
            state_q <= S_WAIT_SWAP;
          end
        end
        S_WAIT_SWAP: begin
          if (frame_done_in && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
          end
          if (do_swap) begin
            state_q <= S_WRITE;
            bank_q  <= ~bank_q;
            mode_q  <= mode_in;
          end
        end
      endcase
    end
  end

  assign wr.wr_addr_out  = addr_q;
  assign wr.wr_data_out  = data_q;
  assign wr.wr_en_out    = en_q;
  assign rd_bank_out     = ~bank_q;
  assign swap_out        = swap_q;
  assign drop_count_out  = drop_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: two configurations driven in parallel
// and compared against a cycle-level reference model.
module tb_cam_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] pix = '0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic        vld = 1'b0;
  logic        fd = 1'b0;
  logic        nf = 1'b0;

  logic        rdb0, sw0, rdb1, sw1;
  logic [15:0] drp0, drp1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  cam_frame_writer_if #(.ADDR_W(18), .OUT_W(8)) wr0 ();
  cam_frame_writer_if #(.ADDR_W(16), .OUT_W(16)) wr1 ();

  cam_frame_writer #(
    .H_RES(320), .V_RES(240), .OUT_W(8), .DECIM_LOG2(0)
  ) u0 (
    .clk_in(clk), .rst_in(rst_n), .mode_in(mode),
    .pixel_in(pix), .hcount_in(hc), .vcount_in(vc),
    .valid_in(vld), .frame_done_in(fd), .nf_in(nf),
    .wr(wr0), .rd_bank_out(rdb0), .swap_out(sw0),
    .drop_count_out(drp0)
  );

  cam_frame_writer #(
    .H_RES(320), .V_RES(240), .OUT_W(16), .DECIM_LOG2(1)
  ) u1 (
    .clk_in(clk), .rst_in(rst_n), .mode_in(mode),
    .pixel_in(pix), .hcount_in(hc), .vcount_in(vc),
    .valid_in(vld), .frame_done_in(fd), .nf_in(nf),
    .wr(wr1), .rd_bank_out(rdb1), .swap_out(sw1),
    .drop_count_out(drp1)
  );

  // reference model state, index = configuration
  int          acc_t[2];
  logic [17:0] acc_addr[2];
  logic [15:0] acc_data[2];
  bit          waiting[2];
  bit          bank[2];
  bit          swp[2];
  bit          eexp[2];
  int          drop[2];
  logic [1:0]  mlat[2];
  logic [17:0] eaddr[2];
  logic [15:0] edata[2];

  function automatic logic [15:0] ref_conv(
    input logic [1:0] m, input logic [15:0] p, input int ow
  );
    int r, g, b, s;
    r = int'(p[15:11]) * 8;
    g = int'(p[10:5]) * 4;
    b = int'(p[4:0]) * 8;
    if (m == 2'd1) return 16'((r / 32) * 32 + (g / 32) * 4 + b / 64);
    if (m == 2'd2 && ow == 16) return p;
    s = r + g + b;
    return 16'(s / 4 + s / 16 + s / 64);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      acc_t[d] = -10;
      waiting[d] = 0;
      bank[d] = 0;
      swp[d] = 0;
      eexp[d] = 0;
      drop[d] = 0;
      mlat[d] = mode;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int st;
      bit busy;
      st = 1 << d;
      eexp[d] = (acc_t[d] == cyc - 1);
      eaddr[d] = acc_addr[d];
      edata[d] = acc_data[d];
      busy = (acc_t[d] >= cyc - 2);
      swp[d] = 0;
      if (!waiting[d]) begin
        if (vld && hc < 320 && vc < 240 && hc % st == 0 && vc % st == 0) begin
          acc_t[d] = cyc;
          acc_addr[d] = 18'(int'(bank[d]) * (1 << (d == 1 ? 15 : 17))
                      + int'(hc) / st + (320 / st) * (int'(vc) / st));
          acc_data[d] = ref_conv(mlat[d], pix, d == 1 ? 16 : 8);
        end
        if (fd) waiting[d] = 1;
      end else begin
        if (fd && drop[d] < 65535) drop[d]++;
        if (nf && !busy) begin
          swp[d] = 1;
          bank[d] = !bank[d];
          waiting[d] = 0;
          mlat[d] = mode;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic en, rb, s;
      logic [17:0] a;
      logic [15:0] dt, dc;
      if (d == 0) begin
        en = wr0.wr_en_out; a = 18'(wr0.wr_addr_out);
        dt = 16'(wr0.wr_data_out); rb = rdb0; s = sw0; dc = drp0;
      end else begin
        en = wr1.wr_en_out; a = 18'(wr1.wr_addr_out);
        dt = wr1.wr_data_out; rb = rdb1; s = sw1; dc = drp1;
      end
      chk($sformatf("u%0d.wr_en", d), en, eexp[d]);
      if (eexp[d]) begin
        chk($sformatf("u%0d.wr_addr", d), a, eaddr[d]);
        chk($sformatf("u%0d.wr_data", d), dt, edata[d]);
      end
      if (!rst_n) begin
        chk($sformatf("u%0d.rst_addr", d), a, 0);
        chk($sformatf("u%0d.rst_data", d), dt, 0);
      end
      chk($sformatf("u%0d.rd_bank", d), rb, !bank[d]);
      chk($sformatf("u%0d.swap", d), s, swp[d]);
      chk($sformatf("u%0d.drop", d), dc, drop[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld = 0; fd = 0; nf = 0;
    #1;
    model_reset();
    check_all();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic put(input int h, input int v, input logic [15:0] p);
    hc = 11'(h); vc = 10'(v); pix = p; vld = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] pix;
    int          h, v;
    bit          en;
    int          off;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'd0, 16'hFFFF,   0,   0, 1,     0, 8'hF4};
    tbl[1] = '{2'd1, 16'hF800,   5,   1, 1,   325, 8'hE0};
    tbl[2] = '{2'd1, 16'h07E0,   5,   1, 1,   325, 8'h1C};
    tbl[3] = '{2'd0, 16'h0000, 319, 239, 1, 76799, 8'h00};
    tbl[4] = '{2'd1, 16'h001F,   0,   1, 1,   320, 8'h03};
    tbl[5] = '{2'd3, 16'hFFFF,   1,   0, 1,     1, 8'hF4};
    tbl[6] = '{2'd0, 16'hF800,   2,   0, 1,     2, 8'h50};
    tbl[7] = '{2'd0, 16'hFFFF, 320,   0, 0,     0, 8'h00};
    tbl[8] = '{2'd0, 16'hFFFF,   0, 240, 0,     0, 8'h00};

    for (int i = 0; i < 9; i++) begin
      mode = tbl[i].mode;
      do_reset();
      put(tbl[i].h, tbl[i].v, tbl[i].pix);
      tick();
      vld = 0;
      tick();
      chk("tbl.wr_en", wr0.wr_en_out, tbl[i].en);
      if (tbl[i].en) begin
        chk("tbl.addr", wr0.wr_addr_out, tbl[i].off);
        chk("tbl.data", wr0.wr_data_out, tbl[i].data);
      end
    end

    // decimation: (2,2) kept, (3,2) dropped by the k=1 instance
    mode = 2'd0;
    do_reset();
    put(2, 2, 16'hFFFF);
    tick();
    put(3, 2, 16'hFFFF);
    tick();
    vld = 0;
    chk("dec.en0", wr1.wr_en_out, 1);
    chk("dec.addr0", wr1.wr_addr_out, 161);
    tick();
    chk("dec.en1", wr1.wr_en_out, 0);
    chk("dec.u0_en1", wr0.wr_en_out, 1);

    // frame commit then display new-frame swaps banks
    put(0, 0, 16'h1234);
    tick();
    put(1, 0, 16'h4321);
    tick();
    vld = 0; fd = 1;
    tick();
    fd = 0;
    repeat (3) tick();
    nf = 1;
    tick();
    nf = 0;
    chk("swp.pulse", sw0, 1);
    chk("swp.rd_bank", rdb0, 0);
    tick();
    chk("swp.pulse_end", sw0, 0);
    put(7, 0, 16'hABCD);
    tick();
    vld = 0;
    tick();
    chk("swp.wr_en", wr0.wr_en_out, 1);
    chk("swp.bank_bit", wr0.wr_addr_out[17], 1);

    // dropped frame, rejected pixels, deferred swap
    fd = 1;
    tick();
    tick();
    fd = 0;
    put(4, 4, 16'hFFFF);
    tick();
    vld = 0;
    tick();
    chk("drp.count", drp0, 1);
    chk("drp.no_wr", wr0.wr_en_out, 0);
    nf = 1;
    tick();
    nf = 0;
    chk("drp.swap", sw0, 1);
    tick();
    put(6, 6, 16'h0F0F);
    fd = 1;
    tick();
    vld = 0; fd = 0; nf = 1;
    tick();
    nf = 0;
    chk("dfr.no_swap", sw0, 0);
    tick();
    chk("dfr.rd_bank", rdb0, 1);
    tick();
    nf = 1;
    tick();
    nf = 0;
    chk("dfr.swap", sw0, 1);
    chk("dfr.rd_bank2", rdb0, 0);

    // random traffic
    mode = 2'd2;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      vld = 1'($urandom_range(0, 1));
      hc = 11'($urandom_range(0, 330));
      vc = 10'($urandom_range(0, 245));
      pix = 16'($urandom);
      fd = ($urandom_range(0, 99) < 3);
      nf = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) mode = 2'($urandom);
      tick();
    end
    vld = 0; fd = 0; nf = 0;
    repeat (3) tick();

    // drop counter saturation
    fd = 1;
    repeat (65540) tick();
    fd = 0;
    chk("sat.drop", drp0, 16'hFFFF);
    chk("sat.drop1", drp1, 16'hFFFF);

    // asynchronous reset with the pipe full
    nf = 1;
    tick();
    nf = 0;
    put(10, 4, 16'hFFFF);
    tick();
    put(12, 4, 16'hFFFF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) tick();
    vld = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("rst.no_wr", wr0.wr_en_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
